// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: aligns stores, extends loads, and retires
// one registered write-back bundle per accepted op over a req/gnt/rvalid data port.
module mem_stage #(
    parameter int MAX_WAIT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    input  logic [31:0] i_ex_alu_result,
    input  logic [31:0] i_ex_rs2_data,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_reg_write,
    input  logic        i_ex_mem_read,
    input  logic        i_ex_mem_write,
    input  logic        i_ex_mem_reg,
    input  logic [31:0] i_ex_mem_instruction,
    output logic        o_mem_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic        o_wb_reg_write,
    output logic [31:0] o_wb_data,
    output logic        o_wb_misaligned,
    output logic        o_wb_bus_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    localparam logic [8:0] MAX_W = 9'(MAX_WAIT);

    state_t      r_state;
    logic [7:0]  r_count;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_reg_write;

    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic        r_wb_reg_write;
    logic [31:0] r_wb_data;
    logic        r_wb_misaligned;
    logic        r_wb_bus_err;

    logic [2:0]  w_funct3;
    logic [1:0]  w_off;
    logic        w_is_mem;
    logic        w_misaligned;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_be;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;
    logic [8:0]  w_cnt_inc;
    logic        w_timeout;
    logic        w_unused;

    assign w_funct3  = i_ex_mem_instruction[14:12];
    assign w_off     = i_ex_alu_result[1:0];
    assign w_is_mem  = i_ex_mem_read | i_ex_mem_write;
    assign w_unused  = &{1'b0, i_ex_mem_reg, i_ex_mem_instruction[31:15], i_ex_mem_instruction[11:0]};

    // A set mem_write marks the op as a store; otherwise a memory op is a load.
    always_comb begin
        w_misaligned = 1'b1;
        if (i_ex_mem_write) begin
            case (w_funct3)
                3'd0:    w_misaligned = 1'b0;
                3'd1:    w_misaligned = w_off[0];
                3'd2:    w_misaligned = (w_off != 2'd0);
                default: w_misaligned = 1'b1;
            endcase
        end else begin
            case (w_funct3)
                3'd0, 3'd4: w_misaligned = 1'b0;
                3'd1, 3'd5: w_misaligned = w_off[0];
                3'd2:       w_misaligned = (w_off != 2'd0);
                default:    w_misaligned = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_st_wdata = 32'd0;
        w_st_be    = 4'b0000;
        if (i_ex_mem_write) begin
            case (w_funct3[1:0])
                2'd0: begin
                    w_st_wdata = {4{i_ex_rs2_data[7:0]}};
                    w_st_be    = 4'b0001 << w_off;
                end
                2'd1: begin
                    w_st_wdata = {2{i_ex_rs2_data[15:0]}};
                    w_st_be    = 4'b0011 << w_off;
                end
                default: begin
                    w_st_wdata = i_ex_rs2_data;
                    w_st_be    = 4'b1111;
                end
            endcase
        end
    end

    assign w_shifted = i_dmem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        case (r_funct3)
            3'd0:    w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'd4:    w_load_data = {24'd0, w_shifted[7:0]};
            3'd1:    w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'd5:    w_load_data = {16'd0, w_shifted[15:0]};
            default: w_load_data = i_dmem_rdata;
        endcase
    end

    // The limit is reached on the MAX_WAIT-th waiting cycle of REQ or RESP.
    assign w_cnt_inc = {1'b0, r_count} + 9'd1;
    assign w_timeout = (w_cnt_inc == MAX_W);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state         <= S_IDLE;
            r_count         <= 8'd0;
            r_addr          <= 32'd0;
            r_wdata         <= 32'd0;
            r_be            <= 4'b0000;
            r_we            <= 1'b0;
            r_funct3        <= 3'd0;
            r_rd            <= 5'd0;
            r_reg_write     <= 1'b0;
            r_wb_valid      <= 1'b0;
            r_wb_rd         <= 5'd0;
            r_wb_reg_write  <= 1'b0;
            r_wb_data       <= 32'd0;
            r_wb_misaligned <= 1'b0;
            r_wb_bus_err    <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        if (!w_is_mem) begin
                            r_wb_valid      <= 1'b1;
                            r_wb_rd         <= i_ex_rd;
                            r_wb_reg_write  <= i_ex_reg_write;
                            r_wb_data       <= i_ex_alu_result;
                            r_wb_misaligned <= 1'b0;
                            r_wb_bus_err    <= 1'b0;
                        end else begin
                            r_addr      <= i_ex_alu_result;
                            r_wdata     <= w_st_wdata;
                            r_be        <= w_st_be;
                            r_we        <= i_ex_mem_write;
                            r_funct3    <= w_funct3;
                            r_rd        <= i_ex_rd;
                            r_reg_write <= i_ex_reg_write;
                            if (w_misaligned) begin
                                r_wb_valid      <= 1'b1;
                                r_wb_rd         <= i_ex_rd;
                                r_wb_reg_write  <= 1'b0;
                                r_wb_data       <= i_ex_alu_result;
                                r_wb_misaligned <= 1'b1;
                                r_wb_bus_err    <= 1'b0;
                            end else begin
                                r_state <= S_REQ;
                                r_count <= 8'd0;
                            end
                        end
                    end
                end
                S_REQ: begin
                    if (i_dmem_gnt) begin
                        if (r_we) begin
                            r_wb_valid      <= 1'b1;
                            r_wb_rd         <= r_rd;
                            r_wb_reg_write  <= 1'b0;
                            r_wb_data       <= r_addr;
                            r_wb_misaligned <= 1'b0;
                            r_wb_bus_err    <= 1'b0;
                            r_state         <= S_IDLE;
                        end else begin
                            r_state <= S_RESP;
                            r_count <= 8'd0;
                        end
                    end else if (w_timeout) begin
                        r_wb_valid      <= 1'b1;
                        r_wb_rd         <= r_rd;
                        r_wb_reg_write  <= 1'b0;
                        r_wb_data       <= r_addr;
                        r_wb_misaligned <= 1'b0;
                        r_wb_bus_err    <= 1'b1;
                        r_state         <= S_IDLE;
                    end else begin
                        r_count <= w_cnt_inc[7:0];
                    end
                end
                S_RESP: begin
                    if (i_dmem_rvalid) begin
                        r_wb_valid      <= 1'b1;
                        r_wb_rd         <= r_rd;
                        r_wb_reg_write  <= r_reg_write;
                        r_wb_data       <= w_load_data;
                        r_wb_misaligned <= 1'b0;
                        r_wb_bus_err    <= 1'b0;
                        r_state         <= S_IDLE;
                    end else if (w_timeout) begin
                        r_wb_valid      <= 1'b1;
                        r_wb_rd         <= r_rd;
                        r_wb_reg_write  <= 1'b0;
                        r_wb_data       <= r_addr;
                        r_wb_misaligned <= 1'b0;
                        r_wb_bus_err    <= 1'b1;
                        r_state         <= S_IDLE;
                    end else begin
                        r_count <= w_cnt_inc[7:0];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_stall     = (r_state != S_IDLE);
    assign o_dmem_req      = (r_state == S_REQ);
    assign o_dmem_we       = r_we;
    assign o_dmem_addr     = {r_addr[31:2], 2'b00};
    assign o_dmem_wdata    = r_wdata;
    assign o_dmem_be       = r_be;
    assign o_wb_valid      = r_wb_valid;
    assign o_wb_rd         = r_wb_rd;
    assign o_wb_reg_write  = r_wb_reg_write;
    assign o_wb_data       = r_wb_data;
    assign o_wb_misaligned = r_wb_misaligned;
    assign o_wb_bus_err    = r_wb_bus_err;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RV32I pipeline. Consumes the EX-stage result bundle (ALU result, store data, rd, control bits, instruction) and performs loads and stores over a variable-latency request/grant/response data-memory port. Handles byte-lane alignment, load sign/zero extension, misalignment detection and bus timeout. Retires exactly one registered write-back bundle per accepted operation and holds the upstream pipeline with `mem_stall` while a memory transaction is outstanding.

## Interface
- `MAX_WAIT`, 255: cycles allowed in REQ or RESP before a bus-error retire; 1..255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  the EX bundle below is valid this cycle.
- `ex_alu_result`  in  32  effective address for memory ops; result for all others.
- `ex_rs2_data`  in  32  store data.
- `ex_rd`  in  5  destination register.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_reg`  in  1 each  EX control bits.
- `ex_mem_instruction`  in  32  instruction; bits [14:12] give the access width.
- `mem_stall`  out  1  combinational; 1 = upstream must hold its bundle.
- `dmem_req`  out  1  request valid; held until granted.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  32  word address, {addr[31:2], 2'b00}.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_be`  out  4  byte enables; 4'b0000 for loads.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  load data valid.
- `dmem_rdata`  in  32  load data word.
- `wb_valid`  out  1  one-cycle pulse per retired op.
- `wb_rd`  out  5  destination register.
- `wb_reg_write`  out  1  forced to 0 on any fault.
- `wb_data`  out  32  write-back value.
- `wb_misaligned`  out  1  misaligned or illegal-width fault.
- `wb_bus_err`  out  1  timeout fault.

## Operation
- FSM states: IDLE, REQ, RESP. `mem_stall` = (state != IDLE).
- Accept = `in_valid` in IDLE. Inputs are ignored in REQ/RESP.
- Non-memory accept (`ex_mem_read` = `ex_mem_write` = 0): WB registers load {rd, reg_write, alu_result}; `wb_valid` = 1; stay IDLE.
- Memory accept:
  - Latch the bundle and compute alignment.
  - Misaligned: retire immediately with `wb_misaligned` = 1 and `wb_reg_write` = 0; no bus request.
  - Otherwise go to REQ.
- Misaligned conditions:
  - H/HU with addr[0] = 1.
  - W with addr[1:0] != 0.
  - Load funct3 in {3, 6, 7}.
  - Store funct3 > 2.
- REQ: `dmem_req` = 1, with `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_be` stable from the latch.
  - On `dmem_gnt`, store: retire (`wb_reg_write` = 0) and go IDLE.
  - On `dmem_gnt`, load: go RESP.
- RESP: on `dmem_rvalid`, retire with the extended load data and go IDLE.
- Store lanes (off = addr[1:0]):
  - SB: wdata = {4{rs2[7:0]}}, be = 4'b0001 << off.
  - SH: wdata = {2{rs2[15:0]}}, be = 4'b0011 << off.
  - SW: wdata = rs2, be = 4'b1111.
- Load extraction:
  - LB/LBU: byte rdata[8*off+7 : 8*off], sign- or zero-extended.
  - LH/LHU: half rdata[8*off+15 : 8*off], off in {0, 2}.
  - LW: full word.
- `wb_data` = load data when `mem_read` = 1, else `alu_result`.
- Wait counter:
  - Cleared on entry to REQ and on entry to RESP; increments each cycle in REQ/RESP.
  - At count == MAX_WAIT with no gnt/rvalid: retire with `wb_bus_err` = 1 and `wb_reg_write` = 0; go IDLE.
  - gnt/rvalid in the same cycle as the limit: success wins.
- `dmem_rvalid` outside RESP is ignored.

## Timing
- Reset (async assert, sync to clk on release): state IDLE, counter 0. All outputs 0: `dmem_req`, `dmem_we`, `dmem_be`, `dmem_addr`, `dmem_wdata`, all `wb_*`, `mem_stall`.
- Reset mid-transaction drops `dmem_req` immediately; the pending op is discarded with no `wb_valid`.
- Non-memory or misaligned op: accepted at edge N, `wb_valid` high for cycle N..N+1. Back-to-back accepts give back-to-back `wb_valid`.
- Store: `dmem_req` high from edge N; gnt seen at edge N+k gives `wb_valid` after N+k. Minimum latency 2 cycles.
- Load: gnt at edge N+k, rvalid at edge N+k+j, `wb_valid` after N+k+j. Minimum latency 3 cycles. rvalid in the gnt cycle is not consumed.
- `wb_*` are registered: they update only on retire, and `wb_valid` deasserts on the following edge.

## Test plan
- ADD result 0x1234 (mem_read = 0, mem_write = 0), rd = 5, 3 consecutive ops -> 3 consecutive `wb_valid` pulses; `wb_data` = 0x1234; `mem_stall` never high.
- SH rs2 = 0xAABBCCDD to addr 0x102, gnt after 2 cycles -> `dmem_addr` = 0x100, `dmem_be` = 4'b1100, `dmem_wdata` = 0xCCDDCCDD; `wb_valid` with `wb_reg_write` = 0; `mem_stall` high for 3 cycles.
- LB addr 0x203, rdata = 0x80112233, gnt immediately, rvalid 1 cycle later -> `wb_data` = 0xFFFFFF80. Same access as LBU -> `wb_data` = 0x00000080.
- LW addr 0x206 -> no `dmem_req`; next cycle `wb_misaligned` = 1, `wb_reg_write` = 0.
- MAX_WAIT = 4, load granted but rvalid never arrives -> `wb_bus_err` = 1 after 4 RESP cycles, state IDLE. Repeat with rvalid on the 4th cycle -> normal retire, `wb_bus_err` = 0.
- Assert `rst` low while in REQ -> `dmem_req` = 0 within the same cycle; no `wb_valid` after release.
